aes_shiftrows_pipe: RTL
=======================

// Module: aes_shiftrows_pipe
// PURPOSE
//  Registered, parametrised Rijndael ShiftRows / InvShiftRows stage with valid/ready handshake.
//  Supports block widths Nb = 4, 6 or 8 columns and a per-beat encrypt/decrypt mode.
//  Uses a 2-entry skid buffer, so a round pipeline can chain it at full throughput.
//  Sits between SubBytes and MixColumns in the round datapath; the AES-only variant is NB=4.
// PARAMETERS
//  NB     4  state columns; legal values 4, 6, 8; anything else is an elaboration error
//  TAG_W  4  width of the sideband tag carried alongside each beat (>=1)
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         asynchronous active-high reset
//  in_valid   in   1         input beat valid
//  in_ready   out  1         stage can accept a beat
//  in_data    in   32*NB     state; byte i=r+4c at [32*NB-1-8i -: 8] (col-major, byte0 at MSB)
//  in_inv     in   1         0=ShiftRows, 1=InvShiftRows; sampled with the beat
//  in_tag     in   TAG_W     sideband, passed through unchanged
//  out_valid  out  1         output beat valid
//  out_ready  in   1         downstream accepts
//  out_data   out  32*NB     permuted state
//  out_tag    out  TAG_W     tag of the beat on out_data
// BEHAVIOUR
//  - Shift offsets s_r: row0=0, row1=1; row2=2,row3=3 for NB=4/6; row2=3,row3=4 for NB=8.
//  - Forward:  out(r,c) = in(r,(c+s_r) mod NB).  Inverse: out(r,c) = in(r,(c-s_r+NB) mod NB).
//  - Permutation is applied at the input; the registers hold permuted data.
//  - Storage: main reg (drives out_*) plus skid reg. Occupancy FSM: EMPTY, ONE, TWO.
//  - in_ready = !skid_valid (registered state, no combinational path from out_ready).
//  - Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
//  - EMPTY: accept -> main<=beat, ONE.
//  - ONE: accept & transfer -> main<=beat, stay ONE. Accept only -> skid<=beat, TWO.
//    Transfer only -> EMPTY.
//  - TWO: no accept. Transfer -> main<=skid, ONE. Otherwise hold.
//  - Latency: 1 cycle from accept in EMPTY, or ONE with transfer, to out_valid.
//    Throughput: 1 beat/cycle while out_ready=1.
//  - out_data/out_tag are stable while out_valid & !out_ready; ordering is strictly FIFO.
//  - in_data/in_inv/in_tag are ignored unless accepted.
//  - Reset (async, any cycle incl. mid-stream):
//    out_valid=0, in_ready=1, FSM=EMPTY, out_data=0, out_tag=0, skid cleared.
//    In-flight beats are dropped.
//  - Mixed modes: consecutive beats may alternate in_inv; each beat uses its own mode.
// CONFIGURATION
//  SHIFTROWS_BYPASS_EN defined:
//    - adds input port in_bypass (1 bit), sampled with the beat.
//    - in_bypass=1 stores in_data unpermuted, regardless of in_inv.
//    - Handshake and latency are unchanged.
//  SHIFTROWS_BYPASS_EN undefined:
//    - port in_bypass is absent; every beat is permuted.
// TESTING
//  1. NB=4, fwd, in=d42711ae_e0bf98f1_b8b45de5_1e415230 (FIPS-197 rnd1)
//     -> out=d4bf5d30_e0b452ae_b84111f1_1e2798e5 one cycle later.
//  2. NB=4, inv, in=d4bf5d30_e0b452ae_b84111f1_1e2798e5 -> out=d42711ae_e0bf98f1_b8b45de5_1e415230.
//  3. NB=8, fwd, in bytes 00..1f ascending -> out column0 word=00050e13; inv of result = input.
//  4. out_ready=0 for 3 cycles while in_valid=1 with tags 1,2,3:
//     - in_ready drops after 2 accepts; tag 3 is held upstream.
//     - On release, tags emerge 1,2,3 with no loss or duplication.
//  5. Continuous stream, out_ready=1, alternating in_inv:
//     - out_valid stays high every cycle after the first.
//     - Each beat's result matches a reference model.
//  6. rst asserted mid-stream with TWO occupied:
//     - out_valid=0, in_ready=1 immediately.
//     - Next beat after release has 1-cycle latency.
//  (BYPASS_EN build) in_bypass=1, any in_inv -> out_data==in_data.

Source files
------------

// File: rtl/aes_shiftrows_pipe.sv
// -----------------------------------------------------------------------------
// aes_shiftrows_pipe
//   Registered Rijndael ShiftRows / InvShiftRows stage with a valid/ready
//   handshake and a two-entry skid buffer. Supports Nb = 4, 6 or 8 columns.
//   Each beat carries its own direction bit and a sideband tag.
//
//   The permutation is applied on the way in, so both the main and the skid
//   register hold already-permuted state. in_ready_o is driven from registered
//   state only, which breaks the combinational path from out_ready_i back
//   upstream.
//
//   Optional feature macro: SHIFTROWS_BYPASS_EN
//     When defined, port in_bypass_i is added. A beat accepted with
//     in_bypass_i=1 is stored unpermuted, whatever the value of in_inv_i.
// -----------------------------------------------------------------------------
module aes_shiftrows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [32*NB-1:0]    in_data_i,
  input  logic                in_inv_i,
`ifdef SHIFTROWS_BYPASS_EN
  input  logic                in_bypass_i,
`endif
  input  logic [TAG_W-1:0]    in_tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [32*NB-1:0]    out_data_o,
  output logic [TAG_W-1:0]    out_tag_o
);

  localparam int W = 32 * NB;

  // Reject unsupported block widths at elaboration time.
  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
    end
    if (TAG_W < 1) begin : g_bad_tag
      $error("aes_shiftrows_pipe: TAG_W must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Rijndael row offsets: rows 2 and 3 shift one further for the 256-bit block.
  function automatic int shift_of(input int r);
    int s;
    case (r)
      0:       s = 0;
      1:       s = 1;
      2:       s = (NB == 8) ? 3 : 2;
      default: s = (NB == 8) ? 4 : 3;
    endcase
    return s;
  endfunction

  // Byte (r,c) lives at index r+4c, counted from the MSB end of the vector.
  function automatic logic [W-1:0] shift_rows(input logic [W-1:0] d,
                                               input logic       inv);
    logic [W-1:0] o;
    int           s;
    int           src_c;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      s = shift_of(r);
      for (int c = 0; c < NB; c++) begin
        src_c = inv ? ((c - s + NB) % NB) : ((c + s) % NB);
        o[W-1-8*(r+4*c) -: 8] = d[W-1-8*(r+4*src_c) -: 8];
      end
    end
    return o;
  endfunction

  state_e             state_q;
  logic               out_valid_q;
  logic               skid_valid_q;
  logic [W-1:0]       main_data_q;
  logic [TAG_W-1:0]   main_tag_q;
  logic [W-1:0]       skid_data_q;
  logic [TAG_W-1:0]   skid_tag_q;

  logic [W-1:0]       beat_data_d;
  logic [TAG_W-1:0]   beat_tag_d;
  logic               accept;
  logic               transfer;

  // Permute the incoming beat and decode the two handshake events.
  always_comb begin
    // NOTE: every signal assigned here gets a value on every path first,
    // otherwise synthesis infers a latch to hold the old value.
    beat_data_d = shift_rows(in_data_i, in_inv_i);
    beat_tag_d  = in_tag_i;
`ifdef SHIFTROWS_BYPASS_EN
    if (in_bypass_i) begin
      beat_data_d = in_data_i;
    end
`endif
    accept   = in_valid_i & in_ready_o;
    transfer = out_valid_o & out_ready_i;
  end

  // Occupancy FSM: EMPTY -> ONE -> TWO, with main feeding the output and skid
  // absorbing the one beat that arrives while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are reset too, because out_data_o must read
      // zero after reset; in-flight beats are simply discarded.
      state_q      <= ST_EMPTY;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_tag_q   <= '0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_data_q <= beat_data_d;
            main_tag_q  <= beat_tag_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && transfer) begin
            main_data_q <= beat_data_d;
            main_tag_q  <= beat_tag_d;
          end else if (accept) begin
            skid_data_q  <= beat_data_d;
            skid_tag_q   <= beat_tag_d;
            skid_valid_q <= 1'b1;
            state_q      <= ST_TWO;
          end else if (transfer) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (transfer) begin
            main_data_q  <= skid_data_q;
            main_tag_q   <= skid_tag_q;
            skid_valid_q <= 1'b0;
            state_q      <= ST_ONE;
          end
        end
        default: begin
          out_valid_q  <= 1'b0;
          skid_valid_q <= 1'b0;
          state_q      <= ST_EMPTY;
        end
      endcase
    end
  end

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_data_q;
  assign out_tag_o   = main_tag_q;

endmodule
